mai_kick_sequencer: RTL and testbench

- Animation and address controller for the Mai kick sprite path.
- Sits between the VGA timing/draw-coordinate generator and the sprite ROM/palette pipeline.
- Sequences the kick move through its ROM animation frames on frame boundaries and converts the current draw coordinate into a ROM address.
- Flags whether the current pixel lies inside the sprite window, with a copy delayed to match the registered colour output.

---
 rtl/mai_kick_sequencer.sv | 130 +++++++++++++
 tb/tb_mai_kick_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mai_kick_sequencer.sv
// Kick-move animation sequencer and sprite ROM address generator for the Mai sprite path.
// Frame/state advance only on frame_tick; window test and ROM address are combinational.
module mai_kick_sequencer #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 96,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 6,
  parameter int COOLDOWN   = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic              kick_req,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  output logic [ADDR_W-1:0] rom_address,
  output logic              sprite_on,
  output logic              sprite_on_q,
  output logic [1:0]        frame_idx,
  output logic              busy
);

  localparam int FRAME_SZ = SPR_W * SPR_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  frame_idx_q;
  logic [7:0]  hold_q;
  logic [7:0]  cool_q;
  logic        pending_q;
  logic        busy_q;
  logic [9:0]  px_q;
  logic [9:0]  py_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      frame_idx_q <= 2'd0;
      hold_q      <= 8'd0;
      cool_q      <= 8'd0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      px_q        <= 10'd0;
      py_q        <= 10'd0;
    end else begin
      // Position only moves at frame boundaries so a frame never tears.
      if (frame_tick) begin
        px_q <= pos_x;
        py_q <= pos_y;
      end
      case (state_q)
        IDLE: begin
          if (frame_tick && (pending_q || kick_req)) begin
            state_q     <= PLAY;
            frame_idx_q <= 2'd1;
            hold_q      <= 8'd0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b1;
          end else if (kick_req) begin
            pending_q <= 1'b1;
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (hold_q == 8'(FRAME_HOLD - 1)) begin
              hold_q <= 8'd0;
              if (frame_idx_q == 2'(NUM_FRAMES - 1)) begin
                frame_idx_q <= 2'd0;
                cool_q      <= 8'd0;
                state_q     <= COOL;
              end else begin
                frame_idx_q <= frame_idx_q + 2'd1;
              end
            end else begin
              hold_q <= hold_q + 8'd1;
            end
          end
        end
        COOL: begin
          if (frame_tick) begin
            if (cool_q == 8'(COOLDOWN - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              cool_q <= cool_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // 11-bit arithmetic keeps px+SPR_W from wrapping near the right screen edge.
  logic [10:0] dx_ext, dy_ext, px_ext, py_ext, rel_x, rel_y;

  assign dx_ext = {1'b0, draw_x};
  assign dy_ext = {1'b0, draw_y};
  assign px_ext = {1'b0, px_q};
  assign py_ext = {1'b0, py_q};
  assign rel_x  = dx_ext - px_ext;
  assign rel_y  = dy_ext - py_ext;

  assign sprite_on = (dx_ext >= px_ext) && (dx_ext < px_ext + 11'(SPR_W)) &&
                     (dy_ext >= py_ext) && (dy_ext < py_ext + 11'(SPR_H));

  assign rom_address = sprite_on
                     ? ADDR_W'(32'(frame_idx_q) * 32'(FRAME_SZ) + 32'(rel_y) * 32'(SPR_W) + 32'(rel_x))
                     : '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) sprite_on_q <= 1'b0;
    else          sprite_on_q <= sprite_on;
  end

  assign frame_idx = frame_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mai_kick_sequencer.sv
// Directed bench for mai_kick_sequencer: table-driven window/address vectors plus animation sequences.
module tb_mai_kick_sequencer;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        kick_req = 1'b0;
  logic [9:0]  pos_x = '0, pos_y = '0, draw_x = '0, draw_y = '0;
  logic [15:0] rom_address;
  logic        sprite_on, sprite_on_q, busy;
  logic [1:0]  frame_idx;

  int n_cmp = 0;
  int n_err = 0;

  mai_kick_sequencer dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .kick_req    (kick_req),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .rom_address (rom_address),
    .sprite_on   (sprite_on),
    .sprite_on_q (sprite_on_q),
    .frame_idx   (frame_idx),
    .busy        (busy)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    string       name;
    logic [9:0]  px, py, dx, dy;
    logic        exp_on;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"origin",        100, 50, 100,  50, 1'b1, 16'd0};
    vecs[1]  = '{"bottom_right",  100, 50, 163, 145, 1'b1, 16'd6143};
    vecs[2]  = '{"right_out",     100, 50, 164,  50, 1'b0, 16'd0};
    vecs[3]  = '{"left_out",      100, 50,  99,  50, 1'b0, 16'd0};
    vecs[4]  = '{"below_out",     100, 50, 100, 146, 1'b0, 16'd0};
    vecs[5]  = '{"last_row",      100, 50, 100, 145, 1'b1, 16'd6080};
    vecs[6]  = '{"edge_639",      600, 10, 639,  10, 1'b1, 16'd39};
    vecs[7]  = '{"edge_left_out", 600, 10, 599,  10, 1'b0, 16'd0};
    vecs[8]  = '{"off_1000_639", 1000, 10, 639,  10, 1'b0, 16'd0};
    vecs[9]  = '{"off_1000_0",   1000, 10,   0,  10, 1'b0, 16'd0};
    vecs[10] = '{"zero_col63",      0,  0,  63,   0, 1'b1, 16'd63};
    vecs[11] = '{"zero_col64",      0,  0,  64,   0, 1'b0, 16'd0};

    // Reset state: latched position must be (0,0) even with pos inputs elsewhere.
    pos_x = 10'd500; pos_y = 10'd500; draw_x = 10'd10; draw_y = 10'd10;
    #12;
    check("rst_frame", 32'(frame_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_on_q", 32'(sprite_on_q), 32'd0);
    check("rst_pos_latch_on", 32'(sprite_on), 32'd1);
    check("rst_pos_latch_addr", 32'(rom_address), 32'd650);
    step(1);
    reset_n = 1'b1;
    step(2);

    for (int i = 0; i < 12; i++) begin
      pos_x = vecs[i].px; pos_y = vecs[i].py;
      do_tick();
      draw_x = vecs[i].dx; draw_y = vecs[i].dy;
      #1;
      check({vecs[i].name, "_on"}, 32'(sprite_on), 32'(vecs[i].exp_on));
      check({vecs[i].name, "_addr"}, 32'(rom_address), 32'(vecs[i].exp_addr));
      step(1);
      check({vecs[i].name, "_on_q"}, 32'(sprite_on_q), 32'(vecs[i].exp_on));
    end

    // Position change without a tick must not move the window.
    pos_x = 10'd100; pos_y = 10'd50;
    do_tick();
    pos_x = 10'd200;
    draw_x = 10'd200; draw_y = 10'd50; #1;
    check("midframe_new_pos_off", 32'(sprite_on), 32'd0);
    draw_x = 10'd100; #1;
    check("midframe_old_pos_on", 32'(sprite_on), 32'd1);
    step(3);
    do_tick();
    draw_x = 10'd200; #1;
    check("after_tick_new_pos_on", 32'(sprite_on), 32'd1);
    check("after_tick_new_pos_addr", 32'(rom_address), 32'd0);

    // Kick pulse then full animation.
    pos_x = 10'd100; pos_y = 10'd50;
    do_tick();
    kick_req = 1'b1; step(1); kick_req = 1'b0;
    step(3);
    check("pending_no_start_frame", 32'(frame_idx), 32'd0);
    check("pending_no_start_busy", 32'(busy), 32'd0);
    do_tick();
    check("kick_frame1", 32'(frame_idx), 32'd1);
    check("kick_busy", 32'(busy), 32'd1);
    draw_x = 10'd101; draw_y = 10'd51; #1;
    check("kick_addr_6209", 32'(rom_address), 32'd6209);
    step(4);
    check("kick_stable_midframe", 32'(frame_idx), 32'd1);
    for (int t = 1; t <= 22; t++) begin
      do_tick();
      if (t == 5)  check("t5_frame1", 32'(frame_idx), 32'd1);
      if (t == 6)  check("t6_frame2", 32'(frame_idx), 32'd2);
      if (t == 12) check("t12_frame3", 32'(frame_idx), 32'd3);
      if (t == 17) check("t17_frame3", 32'(frame_idx), 32'd3);
      if (t == 18) begin
        check("t18_frame0", 32'(frame_idx), 32'd0);
        check("t18_busy", 32'(busy), 32'd1);
      end
      if (t == 21) check("t21_busy", 32'(busy), 32'd1);
      if (t == 22) check("t22_idle", 32'(busy), 32'd0);
    end

    // Held kick: no retrigger during COOL, restart once IDLE is reached.
    kick_req = 1'b1;
    do_tick();
    check("held_frame1", 32'(frame_idx), 32'd1);
    for (int t = 1; t <= 22; t++) begin
      do_tick();
      if (t >= 18) begin
        check("held_cool_frame0", 32'(frame_idx), 32'd0);
      end
      if (t == 21) check("held_cool_busy", 32'(busy), 32'd1);
    end
    check("held_idle_busy", 32'(busy), 32'd0);
    step(2);
    check("held_idle_waits_tick", 32'(frame_idx), 32'd0);
    do_tick();
    check("held_restart_frame1", 32'(frame_idx), 32'd1);
    kick_req = 1'b0;

    // Async reset during PLAY frame 2.
    for (int t = 0; t < 6; t++) do_tick();
    check("pre_rst_frame2", 32'(frame_idx), 32'd2);
    step(1);
    #3;
    kick_req = 1'b1;
    reset_n = 1'b0;
    #1;
    check("async_rst_frame", 32'(frame_idx), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    kick_req = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(2);
    do_tick();
    check("post_rst_no_kick_busy", 32'(busy), 32'd0);
    check("post_rst_no_kick_frame", 32'(frame_idx), 32'd0);
    // Request arriving in the same cycle as the tick starts the kick.
    kick_req = 1'b1;
    do_tick();
    kick_req = 1'b0;
    check("same_cycle_kick_frame", 32'(frame_idx), 32'd1);
    check("same_cycle_kick_busy", 32'(busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
